// File: rtl/hazard_pkg.sv
// Shared types and constants for the load-use hazard scoreboard.
// Register fields are held zero-extended to REG_AW_MAX bits so one entry type serves any REG_AW up to that width.
package hazard_pkg;

    localparam int REG_AW_DEF = 5;
    localparam int REG_AW_MAX = 8;
    localparam logic [REG_AW_MAX-1:0] REG_ZERO = '0;

    typedef struct packed {
        logic                  valid;
        logic [REG_AW_MAX-1:0] rd;
    } pending_entry_t;

    // A source hits a destination only when it is actually read and is not the hardwired zero register.
    function automatic logic src_hit(
        input logic                  used,
        input logic [REG_AW_MAX-1:0] src,
        input logic [REG_AW_MAX-1:0] rd
    );
        return used && (src != REG_ZERO) && (src == rd);
    endfunction

endpackage

// File: rtl/pending_fifo.sv
// Circular FIFO of outstanding load destinations, program order, all entries visible for parallel compare.
// Caller qualifies push/pop; pointers wrap naturally because DEPTH is a power of two.
module pending_fifo
    import hazard_pkg::*;
#(
    parameter int  DEPTH = 4,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = PW + 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        push,
    input  logic                        pop,
    input  logic [REG_AW_MAX-1:0]       push_rd,
    output pending_entry_t [DEPTH-1:0]  entries,
    output logic [PW-1:0]               head_idx,
    output logic [REG_AW_MAX-1:0]       head_rd,
    output logic [CW-1:0]               count,
    output logic                        full,
    output logic                        empty
);

    pending_entry_t [DEPTH-1:0] entries_reg;
    logic [PW-1:0]              wr_ptr_reg;
    logic [PW-1:0]              rd_ptr_reg;
    logic [CW-1:0]              count_reg;

    // Push is written after the pop clear so a full push+pop on the same slot leaves it valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            entries_reg <= '0;
            wr_ptr_reg  <= '0;
            rd_ptr_reg  <= '0;
            count_reg   <= '0;
        end else begin
            if (pop) begin
                entries_reg[rd_ptr_reg].valid <= 1'b0;
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            if (push) begin
                entries_reg[wr_ptr_reg] <= '{valid: 1'b1, rd: push_rd};
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            count_reg <= count_reg + CW'(push) - CW'(pop);
        end
    end

    assign entries  = entries_reg;
    assign head_idx = rd_ptr_reg;
    assign head_rd  = entries_reg[rd_ptr_reg].rd;
    assign count    = count_reg;
    assign full     = (count_reg == CW'(DEPTH));
    assign empty    = (count_reg == '0);

endmodule

// File: rtl/load_hazard_scoreboard.sv
// Load-use hazard scoreboard: tracks in-flight loads and stalls ID on a dependent source or a full tracker.
// Optional macro LOAD_HAZARD_WB_BYPASS_EN: a head entry retiring this cycle is forwarded by WB and does not stall.
module load_hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int  REG_AW      = REG_AW_DEF,
    parameter int  MAX_PENDING = 4,
    localparam int PW          = $clog2(MAX_PENDING),
    localparam int CW          = PW + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              issue_valid,
    input  logic [REG_AW-1:0] issue_rd,
    input  logic              cmpl_valid,
    input  logic [REG_AW-1:0] cmpl_rd,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_rs_used,
    input  logic              id_rt_used,
    input  logic              id_is_load,
    output logic              stall,
    output logic              full,
    output logic [CW-1:0]     pending_cnt,
    output logic              err
);

    pending_entry_t [MAX_PENDING-1:0] entries;
    logic [REG_AW_MAX-1:0]            head_rd;
    logic [CW-1:0]                    count;
    logic                             fifo_full;
    logic                             fifo_empty;
    logic [MAX_PENDING-1:0]           live;
    logic [MAX_PENDING-1:0]           hit;
    logic                             do_push;
    logic                             do_pop;
    logic                             overflow;
    logic                             underflow;
    logic                             rd_mismatch;
    logic                             issue_hit;
    logic                             load_stall;
    logic                             err_reg;

    logic [REG_AW_MAX-1:0] rs_ext;
    logic [REG_AW_MAX-1:0] rt_ext;
    logic [REG_AW_MAX-1:0] issue_ext;
    logic [REG_AW_MAX-1:0] cmpl_ext;

    assign rs_ext    = REG_AW_MAX'(id_rs);
    assign rt_ext    = REG_AW_MAX'(id_rt);
    assign issue_ext = REG_AW_MAX'(issue_rd);
    assign cmpl_ext  = REG_AW_MAX'(cmpl_rd);

    // A pop on an empty tracker is ignored; a push while full is dropped unless a pop frees the slot.
    assign do_pop      = cmpl_valid & ~fifo_empty;
    assign do_push     = issue_valid & (~fifo_full | do_pop);
    assign overflow    = issue_valid & fifo_full & ~cmpl_valid;
    assign underflow   = cmpl_valid & fifo_empty;
    assign rd_mismatch = do_pop & (head_rd != cmpl_ext);

`ifdef LOAD_HAZARD_WB_BYPASS_EN
    logic [PW-1:0] head_idx;
`endif

    pending_fifo #(
        .DEPTH (MAX_PENDING)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (do_push),
        .pop      (do_pop),
        .push_rd  (issue_ext),
        .entries  (entries),
`ifdef LOAD_HAZARD_WB_BYPASS_EN
        .head_idx (head_idx),
`else
        .head_idx (),
`endif
        .head_rd  (head_rd),
        .count    (count),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    for (genvar gi = 0; gi < MAX_PENDING; gi++) begin : g_cmp
`ifdef LOAD_HAZARD_WB_BYPASS_EN
        assign live[gi] = entries[gi].valid & ~(do_pop & (head_idx == PW'(gi)));
`else
        assign live[gi] = entries[gi].valid;
`endif
        assign hit[gi] = live[gi] & (src_hit(id_rs_used, rs_ext, entries[gi].rd) |
                                     src_hit(id_rt_used, rt_ext, entries[gi].rd));
    end

    assign issue_hit  = issue_valid & (src_hit(id_rs_used, rs_ext, issue_ext) |
                                       src_hit(id_rt_used, rt_ext, issue_ext));
    assign load_stall = id_is_load & fifo_full & ~cmpl_valid;
    assign stall      = (|hit) | issue_hit | load_stall;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_reg <= 1'b0;
        end else if (overflow | underflow | rd_mismatch) begin
            err_reg <= 1'b1;
        end
    end

    assign err         = err_reg;
    assign full        = fifo_full;
    assign pending_cnt = count;

endmodule

// File: doc/load_hazard_scoreboard.md
LOAD_HAZARD_SCOREBOARD -- requirements
Module: load_hazard_scoreboard

Interface
REQ-001 SHALL have parameter REG_AW, default 5: register-address width.
REQ-002 SHALL have parameter MAX_PENDING, default 4 (power of two, 2..16): number of outstanding loads tracked.
REQ-003 SHALL have port clk, input, 1: sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1: reset, asynchronous, active-high.
REQ-005 SHALL have port issue_valid, input, 1: a load leaves EX toward memory this cycle.
REQ-006 SHALL have port issue_rd, input, REG_AW: destination register of the issuing load.
REQ-007 SHALL have port cmpl_valid, input, 1: the oldest outstanding load returns data to WB this cycle.
REQ-008 SHALL have port cmpl_rd, input, REG_AW: destination register of the returning load.
REQ-009 SHALL have ports id_rs and id_rt, input, REG_AW each: source registers of the instruction in ID.
REQ-010 SHALL have ports id_rs_used and id_rt_used, input, 1 each: the corresponding source is read.
REQ-011 SHALL have port id_is_load, input, 1: the instruction in ID is a load.
REQ-012 SHALL have port stall, output, 1: hold IF/ID and insert a bubble into ID/EX.
REQ-013 SHALL have port full, output, 1: MAX_PENDING loads are outstanding.
REQ-014 SHALL have port pending_cnt, output, $clog2(MAX_PENDING)+1: number of outstanding loads.
REQ-015 SHALL have port err, output, 1: sticky protocol-error flag.

Function
REQ-016 SHALL hold outstanding loads in program order in a circular FIFO with wr_ptr, rd_ptr and count.
REQ-017 SHALL push issue_rd on issue_valid, and pop the head on cmpl_valid, both at the clock edge.
REQ-018 SHALL, on simultaneous push and pop, perform both and leave count unchanged; this is legal when full.
REQ-019 SHALL drive stall combinationally: high when an enabled ID source (id_rs/id_rt gated by its *_used) equals the rd of any valid entry or equals issue_rd while issue_valid is high.
REQ-020 SHALL never treat register 0 as a match.
REQ-021 SHALL also assert stall when id_is_load=1 and count=MAX_PENDING with no pop this cycle.
REQ-022 SHALL set err when a push arrives while full with no pop (overflow), and SHALL drop that push.
REQ-023 SHALL set err when a pop arrives while empty (underflow), and SHALL leave the state unchanged.
REQ-024 SHALL set err when cmpl_rd differs from the head entry's rd.
REQ-025 SHALL keep err set until reset.
REQ-026 SHALL wrap the pointers modulo MAX_PENDING.
REQ-027 SHALL drive full and pending_cnt from registered state only.

Reset
REQ-028 SHALL clear pointers, count, entry valid bits and err asynchronously while rst=1, giving stall=0 (no issue_valid), full=0, pending_cnt=0, err=0.
REQ-029 SHALL discard all outstanding entries on a mid-operation reset; completions after reset count as underflow.

Configuration
REQ-030 SHALL honour macro LOAD_HAZARD_WB_BYPASS_EN.
REQ-031 With LOAD_HAZARD_WB_BYPASS_EN defined, a head entry being popped this cycle SHALL NOT cause stall, because WB forwards the data.
REQ-032 Without LOAD_HAZARD_WB_BYPASS_EN, the head SHALL cause stall until the cycle after its pop.

Structure
REQ-033 SHALL take REG_AW default, REG_ZERO constant and a pending-entry typedef {valid, rd} from shared package hazard_pkg.
REQ-034 SHALL implement the FIFO as sub-module pending_fifo with parameterised depth, exposing all entries for parallel compare.

Verification
REQ-035 SHALL cover: issue_valid, issue_rd=8 with id_rs=8, id_rs_used=1 in the same cycle -> stall=1 that cycle; pending_cnt=1 next cycle.
REQ-036 SHALL cover: 4 issues (rd 1,2,3,4) with MAX_PENDING=4 -> full=1; id_is_load=1 -> stall=1; push plus pop in the same cycle -> pending_cnt stays 4, err=0.
REQ-037 SHALL cover: entry rd=5 at head, cmpl_valid with cmpl_rd=5, id_rt=5 -> stall=0 with the macro defined, stall=1 without it.
REQ-038 SHALL cover: issue_rd=0 followed by id_rs=0 -> stall=0.
REQ-039 SHALL cover: cmpl_valid while empty, or cmpl_rd=7 against head rd=6 -> err=1 next cycle, staying 1 until rst.
REQ-040 SHALL cover: rst pulsed with 3 entries pending -> pending_cnt=0 and stall=0 immediately, without waiting for a clock edge.
